// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 streaming front-end.
// Word 0 of a block is the most significant 32 bits.
package sm4_pkg;

    localparam int SM4_BLK_W  = 128;
    localparam int SM4_WORD_W = 32;
    localparam int SM4_WORDS  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } sm4_stream_state_t;

    function automatic logic [SM4_BLK_W-1:0] sm4_put_word(
        input logic [SM4_BLK_W-1:0]  blk,
        input logic [1:0]            idx,
        input logic [SM4_WORD_W-1:0] w
    );
        logic [SM4_BLK_W-1:0] r;
        r = blk;
        r[SM4_BLK_W-1-SM4_WORD_W*int'(idx) -: SM4_WORD_W] = w;
        return r;
    endfunction

    function automatic logic [SM4_WORD_W-1:0] sm4_get_word(
        input logic [SM4_BLK_W-1:0] blk,
        input logic [1:0]           idx
    );
        return blk[SM4_BLK_W-1-SM4_WORD_W*int'(idx) -: SM4_WORD_W];
    endfunction

endpackage

// File: rtl/sm4_stream_ctrl_if.sv
// 32-bit valid/ready word streams in (S) and out (M) of the SM4 front-end.
interface sm4_stream_ctrl_if;
    import sm4_pkg::*;

    logic [SM4_WORD_W-1:0] iS_data;
    logic                  iS_valid;
    logic                  oS_ready;
    logic [SM4_WORD_W-1:0] oM_data;
    logic                  oM_valid;
    logic                  iM_ready;

    modport slave (
        input  iS_data, iS_valid, iM_ready,
        output oS_ready, oM_data, oM_valid
    );

    modport master (
        output iS_data, iS_valid, iM_ready,
        input  oS_ready, oM_data, oM_valid
    );

endinterface

// File: rtl/sm4_word_unpacker.sv
// Holds one 128-bit result and streams it out MSW first as four words.
// oDone pulses combinationally on the handshake of the last word.
module sm4_word_unpacker
    import sm4_pkg::*;
(
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iLoad,
    input  logic [SM4_BLK_W-1:0]  iResult,
    input  logic                  iM_ready,
    output logic [SM4_WORD_W-1:0] oM_data,
    output logic                  oM_valid,
    output logic                  oDone
);

    logic [SM4_BLK_W-1:0] res_q, res_d;
    logic [1:0]           idx_q, idx_d;
    logic                 vld_q, vld_d;

    always_comb begin
        res_d = res_q;
        idx_d = idx_q;
        vld_d = vld_q;
        oDone = 1'b0;
        if (iLoad) begin
            res_d = iResult;
            idx_d = 2'd0;
            vld_d = 1'b1;
        end else if (vld_q && iM_ready) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'(SM4_WORDS-1)) begin
                vld_d = 1'b0;
                oDone = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            res_q <= '0;
            idx_q <= 2'd0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            idx_q <= idx_d;
            vld_q <= vld_d;
        end
    end

    assign oM_data  = sm4_get_word(res_q, idx_q);
    assign oM_valid = vld_q;

endmodule

// File: rtl/sm4_stream_ctrl.sv
// Packs a word stream into SM4 blocks, sequences the core, unpacks results.
// Define SM4_STREAM_CBC_EN to add IV ports and CBC chaining.
module sm4_stream_ctrl
    import sm4_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 iClk,
    input  logic                 iReset,
`ifdef SM4_STREAM_CBC_EN
    input  logic [SM4_BLK_W-1:0] iIv,
    input  logic                 iIvLoad,
`endif
    input  logic [SM4_BLK_W-1:0] iKey,
    input  logic                 iKeyLoad,
    input  logic                 iMode,
    sm4_stream_ctrl_if.slave     sif,
    output logic [SM4_BLK_W-1:0] oCoreKey,
    output logic [SM4_BLK_W-1:0] oCoreData,
    output logic                 oCoreSel,
    output logic                 oKeyExpEn,
    output logic                 oEncDecEn,
    input  logic                 iKeyExpReady,
    input  logic                 iCoreReady,
    input  logic [SM4_BLK_W-1:0] iCoreResult,
    output logic                 oKeyValid,
    output logic                 oBusy,
    output logic [CNT_W-1:0]     oBlockCnt
);

    sm4_stream_state_t    state_q, state_d;
    logic [1:0]           widx_q, widx_d;
    logic [SM4_BLK_W-1:0] blk_q, blk_d;
    logic [SM4_BLK_W-1:0] key_q, key_d;
    logic [SM4_BLK_W-1:0] shadow_q, shadow_d;
    logic                 pend_q, pend_d;
    logic                 sel_q, sel_d;
    logic                 kv_q, kv_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 s_ready;
    logic                 s_hs;
    logic                 ld;
    logic                 enter_kx;
    logic                 drain_done;
    logic [SM4_BLK_W-1:0] res_in;

    // A pending key request must win over the first word of a new block.
    assign s_ready = (state_q == ST_LOAD) && !((widx_q == 2'd0) && pend_q);
    assign s_hs    = sif.iS_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        blk_d    = blk_q;
        key_d    = key_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        sel_d    = sel_q;
        kv_d     = kv_q;
        cnt_d    = cnt_q;
        ld       = 1'b0;
        enter_kx = 1'b0;
        if (iKeyLoad) begin
            pend_d   = 1'b1;
            shadow_d = iKey;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (pend_q) enter_kx = 1'b1;
            end
            ST_KEYEXP: begin
                if (iKeyExpReady) begin
                    kv_d    = 1'b1;
                    widx_d  = 2'd0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if ((widx_q == 2'd0) && pend_q) begin
                    enter_kx = 1'b1;
                end else if (s_hs) begin
                    blk_d  = sm4_put_word(blk_q, widx_q, sif.iS_data);
                    widx_d = widx_q + 2'd1;
                    if (widx_q == 2'(SM4_WORDS-1)) begin
                        sel_d   = iMode;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (iCoreReady) begin
                    ld      = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    widx_d = 2'd0;
                    if (pend_q) enter_kx = 1'b1;
                    else        state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A pulse landing on the entry cycle stays pending for a re-run.
        if (enter_kx) begin
            state_d = ST_KEYEXP;
            key_d   = shadow_q;
            kv_d    = 1'b0;
            pend_d  = iKeyLoad;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q  <= ST_IDLE;
            widx_q   <= 2'd0;
            blk_q    <= '0;
            key_q    <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            sel_q    <= 1'b0;
            kv_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            blk_q    <= blk_d;
            key_q    <= key_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            sel_q    <= sel_d;
            kv_q     <= kv_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef SM4_STREAM_CBC_EN
    logic [SM4_BLK_W-1:0] chain_q, chain_d;
    logic                 iv_ok;

    assign iv_ok = (state_q == ST_IDLE) ||
                   ((state_q == ST_LOAD) && (widx_q == 2'd0));

    always_comb begin
        chain_d = chain_q;
        if ((state_q == ST_RUN) && iCoreReady) begin
            chain_d = sel_q ? blk_q : iCoreResult;
        end else if (iIvLoad && iv_ok) begin
            chain_d = iIv;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) chain_q <= '0;
        else        chain_q <= chain_d;
    end

    assign oCoreData = sel_q ? blk_q : (blk_q ^ chain_q);
    assign res_in    = sel_q ? (iCoreResult ^ chain_q) : iCoreResult;
`else
    assign oCoreData = blk_q;
    assign res_in    = iCoreResult;
`endif

    sm4_word_unpacker u_unpack (
        .iClk     (iClk),
        .iReset   (iReset),
        .iLoad    (ld),
        .iResult  (res_in),
        .iM_ready (sif.iM_ready),
        .oM_data  (sif.oM_data),
        .oM_valid (sif.oM_valid),
        .oDone    (drain_done)
    );

    assign sif.oS_ready = s_ready;
    assign oCoreKey     = key_q;
    assign oCoreSel     = sel_q;
    assign oKeyExpEn    = (state_q == ST_KEYEXP);
    assign oEncDecEn    = (state_q == ST_RUN);
    assign oKeyValid    = kv_q;
    assign oBusy        = (state_q != ST_IDLE);
    assign oBlockCnt    = cnt_q;

endmodule

// File: doc/sm4_stream_ctrl.md
# sm4_stream_ctrl

Streaming front-end for the `sm4_top` core. It packs a 32-bit valid/ready input word stream into 128-bit blocks and sequences the core's key-expansion and encrypt/decrypt handshakes. It then unpacks each 128-bit result into a 32-bit valid/ready output stream. It sits between a DMA/FIFO word source and the core, in parallel with the register-mapped bus path, so bulk data flows without per-word CPU writes.

## Interface
Parameters:
- `CNT_W`, 16, width of the processed-block counter.

Ports:
- `iClk`  in  1  clock.
- `iReset`  in  1  asynchronous, active-high reset.
- `iKey`  in  128  user key, sampled on `iKeyLoad`.
- `iKeyLoad`  in  1  one-cycle pulse that requests key (re)expansion.
- `iMode`  in  1  0 = encrypt, 1 = decrypt; sampled at each block start.
- `iS_data`  in  32  input word.
- `iS_valid`  in  1  input word valid.
- `oS_ready`  out  1  input word accepted when high with `iS_valid`.
- `oM_data`  out  32  output word.
- `oM_valid`  out  1  output word valid.
- `iM_ready`  in  1  output sink ready.
- `oCoreKey`  out  128  to core `user_key_in`.
- `oCoreData`  out  128  to core `data_in`.
- `oCoreSel`  out  1  to core `encdec_sel_in`.
- `oKeyExpEn`  out  1  to core `enable_key_exp_and_valid_data_in`.
- `oEncDecEn`  out  1  to core `encdec_enable_in`.
- `iKeyExpReady`  in  1  from core `key_exp_ready_out`.
- `iCoreReady`  in  1  from core `ready_out`.
- `iCoreResult`  in  128  from core `result_out`.
- `oKeyValid`  out  1  round keys are expanded and usable.
- `oBusy`  out  1  high in any state other than IDLE, or when LOAD holds partial data.
- `oBlockCnt`  out  CNT_W  count of completed blocks; wraps modulo 2^CNT_W.

## Operation
States: IDLE, KEYEXP, LOAD, RUN, DRAIN.
- IDLE:
  - `oS_ready` = 0.
  - A pending key request moves to KEYEXP.
- KEYEXP:
  - Latch `iKey` into `oCoreKey` on entry.
  - Hold `oKeyExpEn` = 1 until `iKeyExpReady` = 1.
  - Then clear `oKeyExpEn`, set `oKeyValid`, and go to LOAD.
- LOAD:
  - `oS_ready` = 1.
  - Each handshake writes `iS_data` into the word slot given by the 2-bit word index. Word 0 goes to `[127:96]`, word 3 to `[31:0]`.
  - After the 4th word, latch `iMode` into `oCoreSel` and go to RUN.
- RUN:
  - Hold `oEncDecEn` = 1 until `iCoreReady`.
  - On `iCoreReady`, capture `iCoreResult` into the result register, drop `oEncDecEn`, increment `oBlockCnt`, and go to DRAIN.
- DRAIN:
  - `oM_valid` = 1 and `oM_data` = current result word, MSW first.
  - Advance the word on each `oM_valid && iM_ready`.
  - After the 4th word go to LOAD, or to KEYEXP if a key request is pending.

Key request handling:
- `iKeyLoad` sets a pending flag, latching `iKey` into a shadow register (the last pulse wins).
- The flag is acted on only from IDLE, from DRAIN completion, or from LOAD with word index 0.
- A key request never splits a block.
- Entering KEYEXP clears `oKeyValid` and the pending flag.

Other rules:
- Reset: all outputs are 0, the state is IDLE, the word index is 0, the counter is 0, and the pending flag is 0.
- `iKeyLoad` arriving in the same cycle that KEYEXP completes stays pending and triggers a second expansion.

## Timing
- `oS_ready`, `oM_valid`, `oKeyExpEn` and `oEncDecEn` are decoded from the registered state. There is no combinational path from `iS_valid` or `iM_ready` to any output.
- LOAD to RUN: RUN is entered in the cycle after the 4th input handshake. `oEncDecEn` rises in that same cycle.
- RUN to DRAIN: `oM_valid` rises 1 cycle after `iCoreReady`.
- Throughput floor: 4 cycles load + 1 + core latency + 1 + 4 cycles drain per block, with no overlap between blocks.
- Backpressure: `oM_data` and `oM_valid` are held stable while `iM_ready` = 0.
- Asynchronous reset mid-block discards the partial block and the core handshakes. `oKeyValid` = 0 after reset.

## Configuration
`SM4_STREAM_CBC_EN`:
- Defined: adds ports `iIv` (in, 128) and `iIvLoad` (in, 1), plus a 128-bit chain register.
  - `iIvLoad` loads the chain register, but only while the FSM is in IDLE or LOAD with word index 0.
  - Encrypt: `oCoreData` = packed block XOR chain; chain <= result.
  - Decrypt: output = result XOR chain; chain <= packed ciphertext.
- Undefined: ECB only. `oCoreData` = packed block and output = result. The ports and chain register are absent.

## Structure
- Shared package `sm4_pkg`:
  - state enum `sm4_stream_state_t`.
  - `SM4_BLK_W` = 128, `SM4_WORD_W` = 32, `SM4_WORDS` = 4.
- One natural sub-module: `sm4_word_unpacker`. It holds the result register, the DRAIN word index and the output valid/ready logic, and signals done after the 4th word.

## Test plan
- Key expansion: key 0123456789abcdeffedcba9876543210, `iKeyLoad` pulse. `oKeyExpEn` holds until `iKeyExpReady`, then `oKeyValid` = 1 and the FSM is in LOAD.
- Encrypt, same key: input words 01234567, 89abcdef, fedcba98, 76543210. Output words are 681edf34, d206965e, 86b3e94f, 536e4246, and `oBlockCnt` = 1.
- Decrypt (`iMode` = 1), same key: the ciphertext words above go in and the plaintext words come back in order.
- Backpressure: `iM_ready` low for 5 cycles mid-DRAIN. `oM_data` is stable, no word is lost or duplicated, and `oS_ready` stays 0.
- Key request mid-block: `iKeyLoad` after the 2nd input word. The current block completes with the old key, then KEYEXP runs before the next LOAD.
- Reset in RUN: `iReset` pulse. All outputs are 0, the state is IDLE, and a fresh key load plus block gives the correct ciphertext. Under `SM4_STREAM_CBC_EN`, two blocks with IV = 0 give the second ciphertext = E(P2 XOR C1).
